// File: rtl/eth_rx_buf_pkg.sv
// Shared definitions for the Ethernet RX frame buffer: register offsets,
// window select bit, FSM state types and the tkeep byte-count helper.
package eth_rx_buf_pkg;

    localparam logic [7:0] REG_STATUS     = 8'h00;
    localparam logic [7:0] REG_RX_LEN     = 8'h04;
    localparam logic [7:0] REG_POP        = 8'h08;
    localparam logic [7:0] REG_DROP_COUNT = 8'h0C;

    localparam int WINDOW_BIT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } wr_state_t;

    typedef enum logic {
        BUS_IDLE    = 1'b0,
        BUS_RD_WAIT = 1'b1
    } bus_state_t;

    // Number of valid bytes in a beat; tkeep is contiguous from bit 0.
    function automatic logic [2:0] keep_bytes(input logic [3:0] keep);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, keep[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/eth_rx_buf_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
module eth_rx_buf_ram #(
    parameter int DEPTH = 1536,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH];
    logic [31:0] rdata_r;

    // Write port: store the accepted beat.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port: one-cycle registered read for BRAM inference.
    always_ff @(posedge clk) begin
        rdata_r <= mem_r[raddr];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/eth_rx_frame_buffer.sv
// Ethernet RX frame buffer: stores whole AXI-Stream frames in a ring of
// fixed-size slots and serves lengths and frame words to the CPU over the
// strobe/done MMIO bus. Frames that do not fit or arrive while full are
// dropped and counted.
module eth_rx_frame_buffer
    import eth_rx_buf_pkg::*;
#(
    parameter int SLOT_COUNT = 4,
    parameter int SLOT_WORDS = 384,
    parameter int DROP_CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        strobe_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [31:0] data_i,
    output logic        done_o,
    output logic [31:0] data_o,
    output logic        irq_o
);

    localparam int SLOT_AW   = $clog2(SLOT_COUNT);
    localparam int PTR_W     = SLOT_AW + 1;
    localparam int IDX_W     = $clog2(SLOT_WORDS + 1);
    localparam int LEN_W     = $clog2(SLOT_WORDS * 4 + 1);
    localparam int RAM_DEPTH = SLOT_COUNT * SLOT_WORDS;
    localparam int RAM_AW    = $clog2(RAM_DEPTH);

    wr_state_t             wr_state_r, wr_next_s;
    bus_state_t            bus_state_r, bus_next_s;
    logic [IDX_W-1:0]      idx_r, idx_next_s, ram_widx_s;
    logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r, count_s;
    logic [LEN_W-1:0]      len_r [SLOT_COUNT];
    logic [LEN_W-1:0]      len_s;
    logic [DROP_CNT_W-1:0] drop_cnt_r;
    logic                  beat_s, slot_free_s, ram_we_s, commit_s, drop_inc_s;
    logic                  pop_s, drop_clr_s, win_oob_s, win_oob_r, win_oob_next_s;
    logic                  done_r, done_next_s, irq_r;
    logic [31:0]           data_r, data_next_s, ram_rdata_s, status_s, rx_len_s;
    logic [RAM_AW-1:0]     ram_waddr_s, ram_raddr_s;
    logic [SLOT_AW-1:0]    wr_slot_s, rd_slot_s;
    logic [8:0]            win_idx_s;
    logic                  unused_ok_s;

    // The buffer never backpressures; it only refuses beats while in reset.
    assign s_axis_tready = ~rst;
    assign beat_s        = s_axis_tvalid & ~rst;

    assign count_s     = wr_ptr_r - rd_ptr_r;
    assign slot_free_s = (count_s < PTR_W'(SLOT_COUNT));
    assign wr_slot_s   = wr_ptr_r[SLOT_AW-1:0];
    assign rd_slot_s   = rd_ptr_r[SLOT_AW-1:0];

    assign win_idx_s   = addr_i[10:2];
    assign win_oob_s   = ({23'd0, win_idx_s} >= 32'(SLOT_WORDS));
    assign ram_waddr_s = RAM_AW'(wr_slot_s) * RAM_AW'(SLOT_WORDS) + RAM_AW'(ram_widx_s);
    assign ram_raddr_s = RAM_AW'(rd_slot_s) * RAM_AW'(SLOT_WORDS)
                       + (win_oob_s ? RAM_AW'(0) : RAM_AW'(win_idx_s));

    assign status_s = {23'd0, 5'(count_s), 3'd0, (count_s != PTR_W'(0))};
    assign rx_len_s = (count_s != PTR_W'(0)) ? 32'(len_r[rd_slot_s]) : 32'd0;

    // Address bits outside the decoded fields and POP write data carry no meaning.
    assign unused_ok_s = ^{addr_i[31:16], addr_i[14:11], addr_i[1:0], data_i};

    eth_rx_buf_ram #(
        .DEPTH (RAM_DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (s_axis_tdata),
        .raddr (ram_raddr_s),
        .rdata (ram_rdata_s)
    );

    // Write FSM next state: place beats into the current slot, commit or drop on tlast.
    always_comb begin
        wr_next_s  = wr_state_r;
        idx_next_s = idx_r;
        ram_we_s   = 1'b0;
        ram_widx_s = idx_r;
        commit_s   = 1'b0;
        drop_inc_s = 1'b0;
        case (wr_state_r)
            IDLE: begin
                if (beat_s) begin
                    if (slot_free_s) begin
                        ram_we_s   = 1'b1;
                        ram_widx_s = IDX_W'(0);
                        if (s_axis_tlast) begin
                            commit_s  = 1'b1;
                            wr_next_s = IDLE;
                        end else begin
                            idx_next_s = IDX_W'(1);
                            wr_next_s  = RECV;
                        end
                    end else if (s_axis_tlast) begin
                        drop_inc_s = 1'b1;
                        wr_next_s  = IDLE;
                    end else begin
                        wr_next_s = DROP;
                    end
                end else begin
                    wr_next_s = IDLE;
                end
            end
            RECV: begin
                if (beat_s) begin
                    if (idx_r == IDX_W'(SLOT_WORDS)) begin
                        // Slot is already full: the frame is oversize.
                        if (s_axis_tlast) begin
                            drop_inc_s = 1'b1;
                            wr_next_s  = IDLE;
                        end else begin
                            wr_next_s = DROP;
                        end
                    end else begin
                        ram_we_s   = 1'b1;
                        idx_next_s = idx_r + IDX_W'(1);
                        if (s_axis_tlast) begin
                            commit_s  = 1'b1;
                            wr_next_s = IDLE;
                        end else begin
                            wr_next_s = RECV;
                        end
                    end
                end else begin
                    wr_next_s = RECV;
                end
            end
            DROP: begin
                if (beat_s && s_axis_tlast) begin
                    drop_inc_s = 1'b1;
                    wr_next_s  = IDLE;
                end else begin
                    wr_next_s = DROP;
                end
            end
            default: begin
                wr_next_s = IDLE;
            end
        endcase
        len_s = (LEN_W'(ram_widx_s) << 2) + LEN_W'(keep_bytes(s_axis_tkeep));
    end

    // Write-side state: FSM, word index, write pointer, slot lengths, drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_r <= IDLE;
            idx_r      <= IDX_W'(0);
            wr_ptr_r   <= PTR_W'(0);
            drop_cnt_r <= DROP_CNT_W'(0);
            for (int i = 0; i < SLOT_COUNT; i++) begin
                len_r[i] <= LEN_W'(0);
            end
        end else begin
            wr_state_r <= wr_next_s;
            idx_r      <= idx_next_s;
            if (commit_s) begin
                len_r[wr_slot_s] <= len_s;
                wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
            end
            if (drop_clr_s) begin
                drop_cnt_r <= DROP_CNT_W'(0);
            end else if (drop_inc_s && (drop_cnt_r != {DROP_CNT_W{1'b1}})) begin
                drop_cnt_r <= drop_cnt_r + DROP_CNT_W'(1);
            end
        end
    end

    // Bus FSM next state: decode strobes, produce read data, pop and clear requests.
    always_comb begin
        bus_next_s     = bus_state_r;
        done_next_s    = 1'b0;
        data_next_s    = 32'd0;
        pop_s          = 1'b0;
        drop_clr_s     = 1'b0;
        win_oob_next_s = win_oob_r;
        case (bus_state_r)
            BUS_IDLE: begin
                if (strobe_i) begin
                    if (addr_i[WINDOW_BIT]) begin
                        if (we_i) begin
                            done_next_s = 1'b1;
                        end else begin
                            win_oob_next_s = win_oob_s;
                            bus_next_s     = BUS_RD_WAIT;
                        end
                    end else if (we_i) begin
                        done_next_s = 1'b1;
                        case (addr_i[7:0])
                            REG_POP:        pop_s      = (count_s != PTR_W'(0));
                            REG_DROP_COUNT: drop_clr_s = 1'b1;
                            default:        pop_s      = 1'b0;
                        endcase
                    end else begin
                        done_next_s = 1'b1;
                        case (addr_i[7:0])
                            REG_STATUS:     data_next_s = status_s;
                            REG_RX_LEN:     data_next_s = rx_len_s;
                            REG_DROP_COUNT: data_next_s = 32'(drop_cnt_r);
                            default:        data_next_s = 32'd0;
                        endcase
                    end
                end else begin
                    bus_next_s = BUS_IDLE;
                end
            end
            BUS_RD_WAIT: begin
                // RAM output now holds the word addressed at the strobe.
                done_next_s = 1'b1;
                data_next_s = win_oob_r ? 32'd0 : ram_rdata_s;
                bus_next_s  = BUS_IDLE;
            end
            default: begin
                bus_next_s = BUS_IDLE;
            end
        endcase
    end

    // Bus-side state: FSM, registered done/data, read pointer, interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_state_r <= BUS_IDLE;
            done_r      <= 1'b0;
            data_r      <= 32'd0;
            win_oob_r   <= 1'b0;
            rd_ptr_r    <= PTR_W'(0);
            irq_r       <= 1'b0;
        end else begin
            bus_state_r <= bus_next_s;
            done_r      <= done_next_s;
            data_r      <= data_next_s;
            win_oob_r   <= win_oob_next_s;
            irq_r       <= (count_s != PTR_W'(0));
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    assign done_o = done_r;
    assign data_o = data_r;
    assign irq_o  = irq_r;

endmodule
